// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: FSM encodings, address field positions, data width
// and the latched request record used by the register responder.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT    = 2'b01,
        ST_RESP    = 2'b10,
        ST_RELEASE = 2'b11
    } wb_state_e;

    localparam int SLV_SEL_BIT = 18;
    localparam int RANGE_LSB   = 4;
    localparam int RANGE_MSB   = 17;
    localparam int DATA_W      = 8;

    // Only address bits below the slave-select bit are kept; the crossbar owns the rest.
    typedef struct packed {
        logic                   we;
        logic [SLV_SEL_BIT-1:0] addr;
        logic [DATA_W-1:0]      wdata;
        logic                   sel;
    } wb_req_t;

endpackage

// File: rtl/wb_reg_decode.sv
// Combinational register decode: address -> register index, range and
// read-only-status flags.
module wb_reg_decode
    import wb_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [RANGE_MSB:0] addr,
    output logic [3:0]         idx,
    output logic               in_range,
    output logic               is_status
);

    assign idx       = addr[3:0];
    assign in_range  = (addr[RANGE_MSB:RANGE_LSB] == '0) && ({1'b0, idx} < 5'(NUM_REGS));
    assign is_status = in_range && (idx == 4'(NUM_REGS - 1));

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone responder for a bank of 8-bit control registers plus one read-only status byte.
// Optional macro WB_REG_SLAVE_ERR_EN: flag out-of-range accesses on WBS_ERR alongside ACK.
module wb_reg_slave
    import wb_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WBS_CYC,
    input  logic                    WBS_STB,
    input  logic                    WBS_WE,
    input  logic [31:0]             WBS_ADDR,
    input  logic [7:0]              WBS_WDATA,
    input  logic                    WBS_SEL,
    output logic                    WBS_STALL,
    output logic                    WBS_ACK,
    output logic [7:0]              WBS_RDATA,
    output logic                    WBS_ERR,
    output logic [8*NUM_REGS-1:0]   REG_OUT,
    output logic [NUM_REGS-1:0]     WR_STROBE,
    input  logic [7:0]              STATUS_IN
);

    wb_state_e                  state, nxt;
    logic [3:0]                 cnt, cnt_nxt;
    wb_req_t                    req, bus_req, cur;
    logic [NUM_REGS-1:0][7:0]   regs;
    logic [7:0]                 rd_mux;
    logic [3:0]                 idx;
    logic                       in_range, is_status;
    logic                       enter_resp;
    logic                       unused_addr;

    assign unused_addr = ^WBS_ADDR[31:SLV_SEL_BIT];

    assign bus_req = '{we: WBS_WE, addr: WBS_ADDR[SLV_SEL_BIT-1:0], wdata: WBS_WDATA, sel: WBS_SEL};
    // With zero wait states the RESP edge is also the accept edge, so decode the live bus.
    assign cur = (state == ST_IDLE) ? bus_req : req;

    wb_reg_decode #(.NUM_REGS(NUM_REGS)) u_decode (
        .addr      (cur.addr[RANGE_MSB:0]),
        .idx       (idx),
        .in_range  (in_range),
        .is_status (is_status)
    );

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            ST_IDLE: begin
                if (WBS_CYC && WBS_STB) begin
                    if (WAIT_CYCLES == 0) begin
                        nxt = ST_RESP;
                    end else begin
                        nxt     = ST_WAIT;
                        cnt_nxt = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!WBS_CYC)       nxt = ST_IDLE;
                else if (cnt == '0) nxt = ST_RESP;
                else                cnt_nxt = cnt - 4'd1;
            end
            ST_RESP:    nxt = ST_RELEASE;
            ST_RELEASE: if (!WBS_STB) nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
    end

    assign enter_resp = (nxt == ST_RESP);

    always_comb begin
        rd_mux = '0;
        if (is_status) begin
            rd_mux = STATUS_IN;
        end else if (in_range) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (idx == 4'(i)) rd_mux = regs[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req       <= '0;
            regs      <= '0;
            WBS_ACK   <= 1'b0;
            WBS_RDATA <= '0;
            WR_STROBE <= '0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            WBS_ACK   <= enter_resp;
            WR_STROBE <= '0;
            if (state == ST_IDLE && WBS_CYC && WBS_STB)
                req <= bus_req;
            if (enter_resp) begin
                if (!cur.we) begin
                    WBS_RDATA <= rd_mux;
                end else if (cur.sel && in_range && !is_status) begin
                    for (int i = 0; i < NUM_REGS - 1; i++) begin
                        if (idx == 4'(i)) begin
                            regs[i]      <= cur.wdata;
                            WR_STROBE[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef WB_REG_SLAVE_ERR_EN
    logic err_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) err_q <= 1'b0;
        else     err_q <= enter_resp && !in_range;
    end
    assign WBS_ERR = err_q;
`else
    assign WBS_ERR = 1'b0;
`endif

    assign WBS_STALL = (state != ST_IDLE);
    assign REG_OUT   = regs;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Directed bench for wb_reg_slave with a scoreboard of expected responses and a
// register model; covers decode, status, range, abort and asynchronous reset.
module tb_wb_reg_slave;

    localparam int NR = 16;
    localparam int W  = 3;
`ifdef WB_REG_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST;
    logic            CYC, STB, WE, SEL;
    logic [31:0]     ADDR;
    logic [7:0]      WDATA, STATUS;
    logic            STALL, ACK, ERR;
    logic [7:0]      RDATA;
    logic [8*NR-1:0] REG_OUT;
    logic [NR-1:0]   WR_STROBE;

    wb_reg_slave #(.NUM_REGS(NR), .WAIT_CYCLES(W)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .WBS_CYC   (CYC),
        .WBS_STB   (STB),
        .WBS_WE    (WE),
        .WBS_ADDR  (ADDR),
        .WBS_WDATA (WDATA),
        .WBS_SEL   (SEL),
        .WBS_STALL (STALL),
        .WBS_ACK   (ACK),
        .WBS_RDATA (RDATA),
        .WBS_ERR   (ERR),
        .REG_OUT   (REG_OUT),
        .WR_STROBE (WR_STROBE),
        .STATUS_IN (STATUS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]    rdata;
        logic [NR-1:0] strobe;
        logic          err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [NR];
    logic [7:0] last_rd;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [8*NR-1:0] exp_regout();
        logic [8*NR-1:0] v;
        v = '0;
        for (int i = 0; i < NR - 1; i++) v[8*i +: 8] = model[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        last_rd = 8'h00;
    endtask

    task automatic txn(input logic we, input logic [31:0] a, input logic [7:0] d, input logic s);
        exp_t       e;
        logic [3:0] idx;
        logic       inr, st;
        int         cyc;
        idx = a[3:0];
        inr = (a[17:4] == 14'd0) && (int'(idx) < NR);
        st  = inr && (int'(idx) == NR - 1);
        e.strobe = '0;
        e.err    = ERR_EN && !inr;
        if (we) begin
            if (s && inr && !st) begin
                model[idx]    = d;
                e.strobe[idx] = 1'b1;
            end
            e.rdata = last_rd;
        end else begin
            e.rdata = !inr ? 8'h00 : (st ? STATUS : model[idx]);
            last_rd = e.rdata;
        end
        sb.push_back(e);

        @(negedge CLK);
        CYC = 1'b1; STB = 1'b1; WE = we; ADDR = a; WDATA = d; SEL = s;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!ACK && cyc < 20);
        e = sb.pop_front();
        check("ack_latency", 128'(cyc), 128'(W + 1));
        check("rdata", 128'(RDATA), 128'(e.rdata));
        check("err", 128'(ERR), 128'(e.err));
        check("wr_strobe", 128'(WR_STROBE), 128'(e.strobe));
        check("reg_out", 128'(REG_OUT), 128'(exp_regout()));

        // STB stays high one extra cycle: RELEASE must not re-accept it.
        @(negedge CLK);
        check("ack_one_cycle", 128'(ACK), 128'(0));
        check("strobe_clear", 128'(WR_STROBE), 128'(0));
        check("stall_release", 128'(STALL), 128'(1));
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        @(negedge CLK);
        check("stall_idle", 128'(STALL), 128'(0));
    endtask

    initial begin
        logic seen_ack;
        logic [NR-1:0] seen_stb;

        RST = 1'b1; CYC = 1'b0; STB = 1'b0; WE = 1'b0; SEL = 1'b0;
        ADDR = '0; WDATA = '0; STATUS = 8'h00;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_stall", 128'(STALL), 128'(0));
        check("rst_ack", 128'(ACK), 128'(0));
        check("rst_err", 128'(ERR), 128'(0));
        check("rst_rdata", 128'(RDATA), 128'(0));
        check("rst_regout", 128'(REG_OUT), 128'(0));
        check("rst_strobe", 128'(WR_STROBE), 128'(0));
        RST = 1'b0;
        @(negedge CLK);

        // Basic write/read, bit 18 ignored, SEL=0 write
        txn(1'b1, 32'h0000_0003, 8'hA5, 1'b1);
        txn(1'b0, 32'h0000_0003, 8'h00, 1'b1);
        txn(1'b1, 32'h0004_0002, 8'h11, 1'b1);
        txn(1'b1, 32'h0004_0002, 8'h5A, 1'b0);
        txn(1'b0, 32'h0000_0002, 8'h00, 1'b1);
        txn(1'b1, 32'h0000_0000, 8'h81, 1'b1);
        txn(1'b1, 32'hFFFC_000E, 8'hE7, 1'b1);
        txn(1'b0, 32'h0000_000E, 8'h00, 1'b1);

        // Read-only status register
        STATUS = 8'h3C;
        txn(1'b0, 32'h0000_000F, 8'h00, 1'b1);
        txn(1'b1, 32'h0000_000F, 8'hFF, 1'b1);
        txn(1'b0, 32'h0000_000F, 8'h00, 1'b1);
        STATUS = 8'hC3;
        txn(1'b0, 32'h0000_000F, 8'h00, 1'b1);

        // Out-of-range accesses
        txn(1'b1, 32'h0000_0010, 8'h99, 1'b1);
        txn(1'b0, 32'h0000_0010, 8'h00, 1'b1);
        txn(1'b0, 32'h0002_0003, 8'h00, 1'b1);

        // Abort: CYC drops during the wait states
        @(negedge CLK);
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADDR = 32'h4; WDATA = 8'h66; SEL = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("abort_wait_stall", 128'(STALL), 128'(1));
        CYC = 1'b0; STB = 1'b0;
        seen_ack = 1'b0; seen_stb = '0;
        repeat (6) begin
            @(negedge CLK);
            seen_ack = seen_ack | ACK;
            seen_stb = seen_stb | WR_STROBE;
        end
        check("abort_no_ack", 128'(seen_ack), 128'(0));
        check("abort_no_strobe", 128'(seen_stb), 128'(0));
        check("abort_stall", 128'(STALL), 128'(0));
        check("abort_regout", 128'(REG_OUT), 128'(exp_regout()));
        txn(1'b1, 32'h0000_0004, 8'h42, 1'b1);

        // Asynchronous reset in the middle of a write
        @(negedge CLK);
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADDR = 32'h1; WDATA = 8'h77; SEL = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        model_reset();
        check("arst_stall", 128'(STALL), 128'(0));
        check("arst_ack", 128'(ACK), 128'(0));
        check("arst_rdata", 128'(RDATA), 128'(0));
        check("arst_regout", 128'(REG_OUT), 128'(0));
        check("arst_strobe", 128'(WR_STROBE), 128'(0));
        check("arst_err", 128'(ERR), 128'(0));
        @(negedge CLK);
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        txn(1'b0, 32'h0000_0001, 8'h00, 1'b1);
        txn(1'b1, 32'h0000_0001, 8'h77, 1'b1);
        txn(1'b0, 32'h0000_0001, 8'h00, 1'b1);

        check("sb_empty", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
